// File: rtl/orgate_seq_pkg.sv
// Shared types and constants for the orgate_3bit sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package orgate_seq_pkg;

    // Operand/result width of the shared OR datapath.
    localparam int ORGATE_W = 3;

    // Controller phases: collecting A, B, C, then presenting the result.
    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_C   = 2'd2,
        S_OUT = 2'd3
    } seq_state_t;

endpackage

// File: rtl/orgate_3bit.sv
// Shared 3-input bitwise OR datapath: y = a | b | c.
// Latency: combinational, zero cycles.
// Backpressure: none; purely combinational.
// Ports: a, b, c (WIDTH-bit operands), y (WIDTH-bit result).
import orgate_seq_pkg::*;

module orgate_3bit #(
    parameter int WIDTH = ORGATE_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] y
);

    assign y = a | b | c;

endmodule

// File: rtl/orgate_3bit_seq.sv
// Serialises three operands into registers A/B/C and presents A|B|C as one result.
// Latency: out_valid rises the cycle after the third operand is accepted.
// Backpressure: in_ready is low while a result is pending; result holds until out_ready.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data operand stream;
//        flush drops a partial group; out_valid/out_ready/out_data result stream;
//        busy flags a held operand or pending result; group_cnt counts result
//        handshakes and exists only when ORGATE_SEQ_COUNT_EN is defined.
import orgate_seq_pkg::*;

module orgate_3bit_seq #(
    parameter int WIDTH = ORGATE_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef ORGATE_SEQ_COUNT_EN
    output logic [CNT_W-1:0] group_cnt,
`endif
    output logic             busy
);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;

    logic in_acc;
    logic out_hs;

    // in_ready is masked by rst combinationally so nothing is offered as
    // accepted while the block is being reset.
    assign in_ready  = (state_q != S_OUT) && !rst;
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_A);
    assign in_acc    = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        case (state_q)
            S_A, S_B, S_C: begin
                // Flush wins over an operand offered in the same cycle.
                if (flush) begin
                    a_d     = '0;
                    b_d     = '0;
                    c_d     = '0;
                    state_d = S_A;
                end else if (in_acc) begin
                    case (state_q)
                        S_A:     begin a_d = in_data; state_d = S_B;   end
                        S_B:     begin b_d = in_data; state_d = S_C;   end
                        default: begin c_d = in_data; state_d = S_OUT; end
                    endcase
                end
            end
            default: begin
                // Flush is ignored here: a pending result is always delivered.
                if (out_hs) begin
                    state_d = S_A;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
        end
    end

    orgate_3bit #(
        .WIDTH (WIDTH)
    ) u_or (
        .a (a_q),
        .b (b_q),
        .c (c_q),
        .y (out_data)
    );

`ifdef ORGATE_SEQ_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Wraps naturally at 2^CNT_W; flushes never reach S_OUT so never count.
    always_comb begin
        cnt_d = cnt_q;
        if (out_hs) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign group_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_orgate_3bit_seq.sv
module tb_orgate_3bit_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_data;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_data;
    logic       busy;
`ifdef ORGATE_SEQ_COUNT_EN
    logic [1:0] group_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: how many operands of the current group are held, the
    // OR of those operands, whether a result is pending and its value, and
    // the number of completed result handshakes.
    int         m_n;
    logic [2:0] m_acc;
    logic       m_pend;
    logic [2:0] m_res;
    int         m_cnt;

    orgate_3bit_seq #(
        .WIDTH (3),
        .CNT_W (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef ORGATE_SEQ_COUNT_EN
        .group_cnt (group_cnt),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance the model across the edge,
    // then compare every visible output shortly after the edge.
    task automatic step(input logic v, input logic [2:0] d, input logic f,
                        input logic ordy, input logic r);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = ordy;
        rst       = r;
        @(posedge clk);
        if (r) begin
            m_n = 0; m_acc = 3'b000; m_pend = 1'b0; m_res = 3'b000; m_cnt = 0;
        end else if (m_pend) begin
            if (ordy) begin
                m_pend = 1'b0;
                m_cnt  = m_cnt + 1;
            end
        end else if (f) begin
            m_n = 0; m_acc = 3'b000;
        end else if (v) begin
            m_acc = m_acc | d;
            m_n   = m_n + 1;
            if (m_n == 3) begin
                m_pend = 1'b1;
                m_res  = m_acc;
                m_n    = 0;
                m_acc  = 3'b000;
            end
        end
        #1;
        chk("in_ready",  {7'd0, in_ready},  {7'd0, (!r && !m_pend)});
        chk("out_valid", {7'd0, out_valid}, {7'd0, m_pend});
        chk("busy",      {7'd0, busy},      {7'd0, (m_pend || m_n > 0)});
        if (m_pend || r)
            chk("out_data", {5'd0, out_data}, {5'd0, m_res});
`ifdef ORGATE_SEQ_COUNT_EN
        chk("group_cnt", {6'd0, group_cnt}, 8'(m_cnt % 4));
`endif
    endtask

    initial begin
        m_n = 0; m_acc = 3'b000; m_pend = 1'b0; m_res = 3'b000; m_cnt = 0;
        in_valid = 1'b1; in_data = 3'b000; flush = 1'b0; out_ready = 1'b0; rst = 1'b1;

        // Reset held two cycles with in_valid high.
        step(1'b1, 3'b101, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'b101, 1'b0, 1'b0, 1'b1);
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);

        // Basic group, result for exactly one cycle.
        step(1'b1, 3'b100, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'b010, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'b001, 1'b0, 1'b1, 1'b0);
        chk("basic_data", {5'd0, out_data}, 8'h07);
        step(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);

        // Backpressure: result held while out_ready is low.
        step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b100, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 3'b011, 1'b0, 1'b0, 1'b0);
        chk("bp_data", {5'd0, out_data}, 8'h04);
        step(1'b1, 3'b011, 1'b0, 1'b1, 1'b0);

        // Flush beats a same-cycle operand, then a zero group.
        step(1'b1, 3'b111, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b101, 1'b1, 1'b0, 1'b0);
        chk("flush_busy", {7'd0, busy}, 8'h00);
        step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("flush_zero", {5'd0, out_data}, 8'h00);
        step(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);

        // Flush while a result is pending is ignored.
        step(1'b1, 3'b001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
        chk("flush_out_vld", {7'd0, out_valid}, 8'h01);
        step(1'b0, 3'b000, 1'b1, 1'b1, 1'b0);

        // Reset in the middle of a group.
        step(1'b1, 3'b011, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'b010, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
        chk("rst_mid_data", {5'd0, out_data}, 8'h02);
        step(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);

        // Several more groups exercise the counter wrap, plus a flushed group.
        for (int g = 0; g < 5; g++) begin
            step(1'b1, 3'(g), 1'b0, 1'b1, 1'b0);
            step(1'b1, 3'b000, 1'b0, 1'b1, 1'b0);
            step(1'b1, 3'b100, 1'b0, 1'b1, 1'b0);
            step(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
        end
        step(1'b1, 3'b110, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'b001, 1'b1, 1'b1, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 3'($urandom),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 49) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
